// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Operand/result bundle between the EX stage and the iterative RV32M
//   multiply/divide unit.
//   master : EX stage side, drives start, funct3, bus_a, bus_b
//   slave  : mul_div_unit, drives busy, done, out
interface mul_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] bus_a;
    logic [DATA_WIDTH-1:0] bus_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] out;

    modport master (
        output start, funct3, bus_a, bus_b,
        input  busy, done, out
    );

    modport slave (
        input  start, funct3, bus_a, bus_b,
        output busy, done, out
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative RV32M multiply/divide unit sitting beside the ALU.
//   Multiply: shift-add, one multiplier bit per clock.
//   Divide:   restoring division, one quotient bit per clock.
//   Both run on magnitudes; the sign is applied once in the FIX state.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - mul_div_unit_if.slave: start/funct3/bus_a/bus_b in,
//            busy/done/out back to the pipeline
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_r;
    logic               neg_r;
    logic [W-1:0]       opnd_r;
    logic [2*W-1:0]     acc_r;
    logic [W-1:0]       out_r;

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // Operand decode at start
    logic signed [W-1:0] a_s;
    logic signed [W-1:0] b_s;
    logic                a_sgn_op, b_sgn_op, a_neg, b_neg;
    logic [W-1:0]        a_mag, b_mag;
    logic                is_div, div_zero, div_ovf, special;
    logic [W-1:0]        special_val;
    logic                accept;

    assign a_s      = bus.bus_a;
    assign b_s      = bus.bus_b;
    assign a_sgn_op = !(bus.funct3 inside {3'b011, 3'b101, 3'b111});
    assign b_sgn_op = a_sgn_op && (bus.funct3 != 3'b010);
    assign a_neg    = a_sgn_op && (a_s < 0);
    assign b_neg    = b_sgn_op && (b_s < 0);
    assign a_mag    = cond_neg(bus.bus_a, a_neg);
    assign b_mag    = cond_neg(bus.bus_b, b_neg);

    assign is_div   = bus.funct3[2];
    assign div_zero = is_div && (bus.bus_b == '0);
    assign div_ovf  = is_div && !bus.funct3[0]
                      && (bus.bus_a == {1'b1, {(W-1){1'b0}}}) && (bus.bus_b == '1);
    assign special  = div_zero || div_ovf;
    assign accept   = bus.start && ((state == IDLE) || (state == DONE));

    always_comb begin
        special_val = '0;
        if (div_zero)
            special_val = bus.funct3[1] ? bus.bus_a : '1;
        else if (!bus.funct3[1])
            special_val = {1'b1, {(W-1){1'b0}}};
    end

    // Iteration step: acc_r = {hi, lo}. Multiply: hi = partial sum, lo =
    // multiplier shifting out. Divide: hi = partial remainder, lo = dividend
    // shifting out while quotient bits shift in.
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic           div_ok;
    logic [2*W-1:0] calc_nxt;

    assign mul_sum   = {1'b0, acc_r[2*W-1:W]} + {1'b0, (acc_r[0] ? opnd_r : {W{1'b0}})};
    assign div_shift = acc_r[2*W-1:W-1];
    assign div_diff  = div_shift - {1'b0, opnd_r};
    assign div_ok    = !div_diff[W];
    assign calc_nxt  = op_r[2]
                       ? {(div_ok ? div_diff[W-1:0] : div_shift[W-1:0]), acc_r[W-2:0], div_ok}
                       : {mul_sum, acc_r[W-1:1]};

    // Sign correction and half select
    logic [2*W-1:0] prod;
    logic [W-1:0]   fix_val;

    assign prod    = cond_neg2(acc_r, neg_r);
    assign fix_val = !op_r[2]
                     ? ((op_r[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W])
                     : cond_neg(op_r[1] ? acc_r[2*W-1:W] : acc_r[W-1:0], neg_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = accept ? (special ? DONE : CALC) : IDLE;
            CALC:       if (cnt == CNT_W'(W - 1)) state_nxt = FIX;
            FIX:        state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_r   <= '0;
            neg_r  <= 1'b0;
            opnd_r <= '0;
            acc_r  <= '0;
            out_r  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_r  <= bus.funct3;
                        // REM/REMU take the dividend's sign; everything else a^b
                        neg_r <= (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        cnt   <= '0;
                        if (special) begin
                            out_r <= special_val;
                        end else if (is_div) begin
                            opnd_r <= b_mag;
                            acc_r  <= {{W{1'b0}}, a_mag};
                        end else begin
                            opnd_r <= a_mag;
                            acc_r  <= {{W{1'b0}}, b_mag};
                        end
                    end
                end
                CALC: begin
                    acc_r <= calc_nxt;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: out_r <= fix_val;
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == CALC) || (state == FIX);
    assign bus.done = (state == DONE);
    assign bus.out  = out_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Table of operations run back-to-back (each started in the previous DONE
//   cycle) against a queue of expected results, plus hand-written sequences
//   for an ignored mid-operation start and an asynchronous reset mid-operation.
module tb_mul_div_unit;
    logic clk;
    logic rst;

    mul_div_unit_if #(.DATA_WIDTH(32)) mif ();

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          edge_k;   // edge index after the start edge where done shows
        int          busy_n;   // cycles with busy=1 before done
        string       nm;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (mif.busy === 1'b1 && mif.done === 1'b1) begin
                bad++;
                $display("FAIL busy_and_done actual=11 required=not both");
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Waits for done at negedges; returns edges elapsed and busy cycles seen.
    task automatic wait_done(input string nm, output int lat, output int bcnt, output bit seen);
        lat = 0; bcnt = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mif.done === 1'b1) begin
                seen = 1;
                break;
            end
            if (mif.busy === 1'b1) bcnt++;
            lat++;
        end
        if (!seen) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            check({nm, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            check({nm, "_out"}, mif.out, exp_q.pop_front());
        end
    endtask

    // Entered just after a negedge; leaves at the negedge where done was seen.
    task automatic run_op(input vec_t v);
        int lat, bcnt;
        bit seen;
        mif.start  = 1'b1;
        mif.funct3 = v.f;
        mif.bus_a  = v.a;
        mif.bus_b  = v.b;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1 mif.start = 1'b0;
        wait_done(v.nm, lat, bcnt, seen);
        check({v.nm, "_done_edge"}, lat, v.edge_k);
        check({v.nm, "_busy_cycles"}, bcnt, v.busy_n);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mif.done === 1'b1) n++;
        end
    endtask

    initial begin
        int  lat, bcnt, n;
        bit  seen;
        vec_t v;

        vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 33, "mul_7_m3"});
        vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 33, "mulh_min_min"});
        vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 33, "mulhu_max"});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 33, "mulhsu_m1_max"});
        vecs.push_back('{3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33, 33, "mulh_m3_5"});
        vecs.push_back('{3'b011, 32'h80000000, 32'd4,        32'h00000002, 33, 33, "mulhu_big_4"});
        vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33, "div_m7_2"});
        vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33, "rem_m7_2"});
        vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33, 33, "div_m7_m2"});
        vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33, 33, "rem_m7_m2"});
        vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       33, 33, "divu_100_7"});
        vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        33, 33, "remu_100_7"});
        vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0,  0,  "div_5_0"});
        vecs.push_back('{3'b110, 32'd5,        32'd0,        32'd5,        0,  0,  "rem_5_0"});
        vecs.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0,  0,  "divu_5_0"});
        vecs.push_back('{3'b111, 32'd5,        32'd0,        32'd5,        0,  0,  "remu_5_0"});
        vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,  0,  "div_ovf"});
        vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0,  0,  "rem_ovf"});
        vecs.push_back('{3'b000, 32'd6,        32'd9,        32'd54,       33, 33, "mul_after_special"});

        rst        = 1'b1;
        mif.start  = 1'b0;
        mif.funct3 = 3'b000;
        mif.bus_a  = '0;
        mif.bus_b  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, mif.busy}, 32'd0);
        check("reset_done", {31'd0, mif.done}, 32'd0);
        check("reset_out",  mif.out, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Back-to-back: each next op is driven in the DONE cycle of the last
        foreach (vecs[i]) run_op(vecs[i]);
        @(negedge clk);

        // start pulsed mid-operation must be ignored
        mif.start  = 1'b1;
        mif.funct3 = 3'b101;
        mif.bus_a  = 32'd100;
        mif.bus_b  = 32'd7;
        exp_q.push_back(32'd14);
        @(posedge clk);
        #1 mif.start = 1'b0;
        repeat (11) @(negedge clk);
        mif.start  = 1'b1;
        mif.funct3 = 3'b000;
        mif.bus_a  = 32'd3;
        mif.bus_b  = 32'd3;
        @(posedge clk);
        #1 mif.start = 1'b0;
        wait_done("ignored_start", lat, bcnt, seen);
        check("ignored_start_done_edge", lat + 11, 33);
        count_dones(40, n);
        check("ignored_start_no_extra_done", n, 0);

        // asynchronous reset mid-multiply
        mif.start  = 1'b1;
        mif.funct3 = 3'b000;
        mif.bus_a  = 32'd7;
        mif.bus_b  = 32'hFFFFFFFD;
        @(posedge clk);
        #1 mif.start = 1'b0;
        repeat (11) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, mif.busy}, 32'd0);
        check("async_rst_done", {31'd0, mif.done}, 32'd0);
        check("async_rst_out",  mif.out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_dones(40, n);
        check("after_rst_no_done", n, 0);

        v = '{3'b101, 32'd9, 32'd3, 32'd3, 33, 33, "divu_9_3_after_rst"};
        run_op(v);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
